gmii_tx_arbiter: RTL
====================

# gmii_tx_arbiter

Frame-granular round-robin arbiter sharing the single GMII transmit port among NUM_REQ frame sources (e.g. UDP, ARP, ICMP engines). It sits between the source engines and the GMII TX output stage, which also feeds the 10/100 nibble path. It grants one source at a time, muxes that source's byte stream onto the GMII outputs, and enforces the inter-frame gap. It also guards against sources that never start and against oversize frames.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- IFG_CYCLES, 12: minimum idle cycles enforced after each frame.
- START_TIMEOUT, 16: cycles a granted source may take to assert its enable.
- MAX_LEN, 1534: maximum cycles of src_en per frame, preamble included.
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- link  in  1  PHY link up; low aborts the current frame.
- req  in  NUM_REQ  per-source request, level; held until the source sees gnt.
- gnt  out  NUM_REQ  one-hot grant, registered.
- src_en  in  NUM_REQ  per-source byte valid; only the granted bit is observed.
- src_txd  in  8*NUM_REQ  per-source byte; source i occupies bits [8i+7:8i].
- gmii_tx_en  out  1  muxed tx enable, registered.
- gmii_txd  out  8  muxed tx data, registered.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse when a grant is revoked because src_en never rose.
- err_oversize  out  1  one-cycle pulse when a frame is truncated at MAX_LEN.

## Operation
- Reset values: state IDLE, gnt 0, gmii_tx_en 0, gmii_txd 0, busy 0, err pulses 0, rr pointer 0, all counters 0.
- State IDLE:
  - Requires link high and any req bit set.
  - Picks the winner by rotating priority: the search starts at index ptr and wraps modulo NUM_REQ.
  - Registers a one-hot gnt and moves to GRANT.
- State GRANT:
  - Waits for src_en[sel].
  - When src_en[sel] rises, moves to XMIT and clears the length counter.
  - Timeout counter runs 0..START_TIMEOUT-1. On expiry: clear gnt, pulse err_timeout, go to IFG.
- State XMIT:
  - Length counter increments on each cycle with src_en[sel] high.
  - src_en[sel] low: clear gnt and go to IFG.
  - Counter reaching MAX_LEN with src_en still high:
    - Force gmii_tx_en low from the next cycle.
    - Clear gnt and pulse err_oversize.
    - Go to IFG; the remainder of the frame is ignored.
- State IFG: counts IFG_CYCLES cycles, then returns to IDLE.
- Pointer rule: on leaving GRANT or XMIT, ptr = sel+1, with wrap to 0 at NUM_REQ. This applies on timeout and truncation too.
- Datapath:
  - In GRANT and XMIT: gmii_tx_en <= src_en[sel], gmii_txd <= src_txd[sel].
  - In all other states: both are 0.
  - gmii_txd is 0 whenever gmii_tx_en is 0.
- Ungranted sources: src_en and src_txd are ignored completely; they never reach the outputs.
- link low in any state:
  - Next edge: state IDLE, gnt 0, gmii_tx_en 0.
  - IFG is skipped and ptr is not changed.
  - No error pulse is raised.
- Requests that arrive during GRANT, XMIT or IFG wait for IDLE.
- Simultaneous requests are resolved only by the rotating order; there are no fixed priorities.

## Timing
- IDLE with req seen at edge k: gnt high at k+1, state GRANT.
- Output latency is exactly one cycle: src_en and src_txd of cycle t appear on gmii at t+1.
- Last source byte at cycle t (src_en low at t+1):
  - gmii_tx_en falls at t+2 and gnt falls at t+2.
  - IFG covers t+2..t+IFG_CYCLES+1.
  - IDLE at t+IFG_CYCLES+2.
  - Earliest next gnt at t+IFG_CYCLES+3.
- Guarantee: gnt reasserts no earlier than IFG_CYCLES+1 cycles after gmii_tx_en falls.
- Timeout: gnt drops START_TIMEOUT+1 cycles after it rose.
- Truncation: gmii_tx_en is high for exactly MAX_LEN cycles.
- Counter widths: $clog2(MAX_LEN+1) and $clog2(max(IFG_CYCLES, START_TIMEOUT)+1); neither counter ever wraps.

## Structure
- Shared package eth_arbi_pkg holds:
  - The state enum: IDLE, GRANT, XMIT, IFG.
  - The default constants ETH_IFG_CYCLES = 12 and ETH_MAX_FRAME = 1534.
- Sub-module gmii_tx_rr_pick is a combinational rotating-priority encoder.
  - Inputs: req, ptr.
  - Outputs: one-hot winner, winner index, any.
  - It is instantiated once.

## Test plan
- Single source: req[0] with a 64-byte frame -> gnt[0] one cycle after req; gmii carries the identical 64 bytes one cycle after src; gmii_tx_en is low for at least 12 cycles afterwards.
- Both requesting continuously, ptr=0 -> grants alternate 0,1,0,1 over 4 frames; each pair of grants is separated by at least 13 cycles after gmii_tx_en falls.
- Granted source holds src_en low -> err_timeout pulses once and gnt drops 17 cycles after rising; the next grant goes to the other source.
- Source streams 2000 bytes -> gmii_tx_en high for exactly 1534 cycles; err_oversize pulses once; trailing bytes never appear on gmii.
- link drops mid-frame at byte 30 -> gmii_tx_en and gnt are 0 on the next edge, state IDLE, no error pulse; with link restored the same source is granted again.
- rst asserted mid-frame -> all outputs 0 asynchronously; after release a new request from source 0 gets gnt[0] first.

Source files
------------

// File: rtl/eth_arbi_pkg.sv
// Shared types and default constants for the GMII transmit arbiter.
package eth_arbi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XMIT  = 2'd2,
    IFG   = 2'd3
  } arb_state_t;

  localparam int ETH_IFG_CYCLES = 12;
  localparam int ETH_MAX_FRAME  = 1534;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/gmii_tx_rr_pick.sv
// Combinational rotating-priority encoder: the search starts at ptr and wraps.
module gmii_tx_rr_pick
  import eth_arbi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand_s;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  // first requester found walking upward from ptr wins
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = wrap_add(ptr, i);
      if (!any && req[cand_s]) begin
        any          = 1'b1;
        win_idx      = cand_s;
        win[cand_s]  = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Frame-granular round-robin arbiter for the shared GMII transmit port,
// with inter-frame gap, start timeout and oversize truncation.
module gmii_tx_arbiter
  import eth_arbi_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int IFG_CYCLES    = ETH_IFG_CYCLES,
  parameter int START_TIMEOUT = 16,
  parameter int MAX_LEN       = ETH_MAX_FRAME
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 link,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic [NUM_REQ-1:0]   src_en,
  input  logic [8*NUM_REQ-1:0] src_txd,
  output logic                 gmii_tx_en,
  output logic [7:0]           gmii_txd,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_oversize
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(max_int(IFG_CYCLES, START_TIMEOUT) + 1);

  arb_state_t         state_r, state_s;
  logic [IDX_W-1:0]   sel_r, sel_s;
  logic [IDX_W-1:0]   ptr_r, ptr_s, ptr_adv_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               tx_en_s;
  logic [7:0]         txd_s;
  logic               err_to_s, err_ov_s;
  logic               cur_en_s;
  logic [7:0]         cur_txd_s;
  logic [NUM_REQ-1:0] pick_win_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;

  gmii_tx_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_r),
    .win     (pick_win_s),
    .win_idx (pick_idx_s),
    .any     (pick_any_s)
  );

  // next-state, grant, datapath and error-pulse decode
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    ptr_s     = ptr_r;
    cnt_s     = cnt_r;
    len_s     = len_r;
    gnt_s     = gnt;
    tx_en_s   = 1'b0;
    txd_s     = 8'h00;
    err_to_s  = 1'b0;
    err_ov_s  = 1'b0;
    cur_en_s  = src_en[sel_r];
    cur_txd_s = src_txd[{sel_r, 3'b000} +: 8];
    if (sel_r == IDX_W'(NUM_REQ - 1)) begin
      ptr_adv_s = '0;
    end else begin
      ptr_adv_s = sel_r + IDX_W'(1);
    end

    // link loss abandons everything without touching ptr or raising errors
    if (!link) begin
      state_s = IDLE;
      gnt_s   = '0;
      cnt_s   = '0;
      len_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            gnt_s   = pick_win_s;
            sel_s   = pick_idx_s;
            cnt_s   = '0;
            state_s = GRANT;
          end else begin
            gnt_s = '0;
          end
        end
        GRANT: begin
          if (cur_en_s) begin
            tx_en_s = 1'b1;
            txd_s   = cur_txd_s;
            len_s   = '0;
            state_s = XMIT;
          end else if (cnt_r == CNT_W'(START_TIMEOUT)) begin
            gnt_s    = '0;
            err_to_s = 1'b1;
            ptr_s    = ptr_adv_s;
            cnt_s    = '0;
            state_s  = IFG;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        XMIT: begin
          // len_r counts bytes forwarded after the first one taken in GRANT
          if (!cur_en_s) begin
            gnt_s   = '0;
            ptr_s   = ptr_adv_s;
            cnt_s   = '0;
            state_s = IFG;
          end else if (len_r == LEN_W'(MAX_LEN - 1)) begin
            gnt_s    = '0;
            err_ov_s = 1'b1;
            ptr_s    = ptr_adv_s;
            cnt_s    = '0;
            state_s  = IFG;
          end else begin
            tx_en_s = 1'b1;
            txd_s   = cur_txd_s;
            len_s   = len_r + LEN_W'(1);
          end
        end
        IFG: begin
          if (cnt_r == CNT_W'(IFG_CYCLES - 1)) begin
            cnt_s   = '0;
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
          gnt_s   = '0;
          cnt_s   = '0;
          len_s   = '0;
        end
      endcase
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      sel_r        <= '0;
      ptr_r        <= '0;
      cnt_r        <= '0;
      len_r        <= '0;
      gnt          <= '0;
      gmii_tx_en   <= 1'b0;
      gmii_txd     <= 8'h00;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      state_r      <= state_s;
      sel_r        <= sel_s;
      ptr_r        <= ptr_s;
      cnt_r        <= cnt_s;
      len_r        <= len_s;
      gnt          <= gnt_s;
      gmii_tx_en   <= tx_en_s;
      gmii_txd     <= txd_s;
      busy         <= (state_s != IDLE);
      err_timeout  <= err_to_s;
      err_oversize <= err_ov_s;
    end
  end

endmodule
